adc_sbc_seq: RTL and testbench
==============================

Name: adc_sbc_seq

Overview:
- Multi-cycle ADC/SBC execution unit for the 6502 ALU path.
- Sits directly around the 8-bit carry-lookahead adder (CLA_8bit). It registers operands, drives the adder, consumes its sum and carry-out, and applies BCD correction.
- The BCD correction is a second pass through the same adder instance.
- Produces the result byte and the C/V/N/Z flags for the status register, using a start/done handshake.

Parameters:
- None. The data width is fixed at 8 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when not busy
- sub  input  1  1 = SBC (A + ~B + C), 0 = ADC (A + B + C)
- decimal  input  1  P.D flag; selects BCD correction
- a  input  8  accumulator operand
- b  input  8  memory operand
- carry_in  input  1  P.C flag
- result  output  8  final result, registered
- c_out  output  1  carry flag
- v_out  output  1  overflow flag
- n_out  output  1  negative flag
- z_out  output  1  zero flag
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock; reset is asynchronous and active-high.
  - On reset: result=0x00, all flags=0, busy=0, done=0, state=IDLE.
  - Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, ADD, ADJ, DONE.
- IDLE/DONE with start=1 at edge E0:
  - Latch a, b' (b' = sub ? ~b : b), carry_in, sub, decimal.
  - Go to ADD; busy=1; done=0.
  - DONE with start=0: go to IDLE; done=0.
- ADD, edge E1:
  - Capture S=sum, Co=carry-out of a + b' + carry_in from the CLA.
  - Capture hc = a[4]^b'[4]^S[4], the carry into bit 4.
  - Capture V = (a[7]==b'[7]) && (S[7]!=a[7]).
  - If decimal=0: result=S, c_out=Co, v_out=V, n_out=S[7], z_out=(S==0); go to DONE.
  - If decimal=1: go to ADJ.
- ADJ, edge E2: the CLA is re-driven with S + corr, carry-in 0.
  - ADC: lowfix = hc || S[3:0]>9; highfix = Co || S>0x99.
  - ADC: corr = {highfix?6:0, lowfix?6:0}; c_out = highfix.
  - SBC: lowfix = !hc; highfix = !Co.
  - SBC: corr low nibble = lowfix?0xA:0 (−6); corr high nibble = highfix?0xA:0 (−6) plus 0xF when lowfix (borrow from the low-nibble subtract), all mod 256; c_out = Co.
  - result = (S + corr) mod 256.
  - n_out and z_out come from the corrected result; v_out = V from the binary pass.
  - Go to DONE.
- DONE: done=1 and busy=0 for exactly this cycle.
  - Outputs hold until the next accepted start.
  - start is accepted in DONE (back-to-back operations).
- Latency, start sample to done high: binary 2 cycles; decimal 3 cycles.
- start while busy (ADD/ADJ) is ignored; no queuing.
- Operand inputs need to be stable only at the start edge.
- Decimal results are defined only for valid BCD operands. Invalid BCD gives whatever the correction rule produces; it is not checked.

Optional Feature:
- Macro: ADC_SBC_DECIMAL_EN.
- Defined: decimal mode as above; the ADJ state exists.
- Undefined (2A03-style core): the decimal input is ignored, the ADJ state is not synthesised, and every operation completes in binary latency (2 cycles).

Test Plan:
- Binary ADC, carry-in set:
  - a=0x00, b=0x77, cin=1 → result 0x78, C=0 V=0 N=0 Z=0.
  - done at the 2nd edge after the start sample.
- Binary ADC, carry and negative:
  - a=0x94, b=0xF7, cin=0 → 0x8B, C=1 V=0 N=1 Z=0.
  - a=0x50, b=0x50 → 0xA0, V=1 N=1 C=0.
- Binary SBC:
  - a=0x00, b=0x01, cin=1 → 0xFF, C=0 N=1.
  - a=0x05, b=0x05, cin=1 → 0x00, C=1 Z=1.
- Decimal ADC with ADC_SBC_DECIMAL_EN defined:
  - 0x58 + 0x46 + 1 → 0x05, C=1 V=1 Z=0; done at the 3rd edge.
  - Decimal SBC 0x40 − 0x13, cin=1 → 0x27, C=1.
  - Decimal SBC 0x46 − 0x12, cin=1 → 0x34, C=1.
- Macro undefined, decimal=1:
  - 0x58 + 0x46 + 1 → 0x9F, C=0 V=1 N=1, binary latency.
- Handshake and reset:
  - start pulsed again during ADD → ignored; exactly one done.
  - start asserted during the done cycle → second operation accepted.
  - rst asserted during ADJ → outputs 0, busy 0, and no done pulse.

Source files
------------

// File: rtl/adc_sbc_seq.sv
// adc_sbc_seq: multi-cycle 6502 ADC/SBC unit around one CLA; BCD correction reuses the adder.
// Decimal mode and the ADJ state exist only when ADC_SBC_DECIMAL_EN is defined.
module cla_8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_c,
  output logic [7:0] o_s,
  output logic       o_c
);
  logic [7:0] w_g, w_p;
  logic [8:0] w_c;
  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  always_comb begin
    w_c[0] = i_c;
    for (int i = 0; i < 8; i++) w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
  end
  assign o_s = w_p ^ w_c[7:0];
  assign o_c = w_c[8];
endmodule

module adc_sbc_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sub,
  input  logic       decimal,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] result,
  output logic       c_out,
  output logic       v_out,
  output logic       n_out,
  output logic       z_out,
  output logic       busy,
  output logic       done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] r_state;
  logic [7:0] r_a, r_b, r_result;
  logic       r_cin, r_c, r_vf, r_n, r_z;
  logic [7:0] w_add_a, w_add_b, w_sum;
  logic       w_add_c, w_co, w_v;
  cla_8bit u_cla (.i_a(w_add_a), .i_b(w_add_b), .i_c(w_add_c), .o_s(w_sum), .o_c(w_co));
  assign w_v = (r_a[7] == r_b[7]) && (w_sum[7] != r_a[7]);
`ifdef ADC_SBC_DECIMAL_EN
  localparam logic [1:0] ADJ = 2'd2;
  logic [7:0] r_s, w_corr;
  logic       r_sub, r_dec, r_co, r_hc, r_v, w_lo, w_hi;
  // SBC correction subtracts 6 per nibble; the low-nibble fix also borrows from the high nibble
  assign w_lo    = r_sub ? !r_hc : (r_hc || r_s[3:0] > 4'd9);
  assign w_hi    = r_sub ? !r_co : (r_co || r_s > 8'h99);
  assign w_corr  = r_sub ? ((w_lo ? 8'hFA : 8'h00) + (w_hi ? 8'hA0 : 8'h00))
                         : {w_hi ? 4'h6 : 4'h0, w_lo ? 4'h6 : 4'h0};
  assign w_add_a = (r_state == ADJ) ? r_s : r_a;
  assign w_add_b = (r_state == ADJ) ? w_corr : r_b;
  assign w_add_c = (r_state == ADJ) ? 1'b0 : r_cin;
  assign busy    = (r_state == ADD) || (r_state == ADJ);
`else
  logic w_unused;
  assign w_unused = decimal;
  assign w_add_a  = r_a;
  assign w_add_b  = r_b;
  assign w_add_c  = r_cin;
  assign busy     = (r_state == ADD);
`endif
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign c_out  = r_c;
  assign v_out  = r_vf;
  assign n_out  = r_n;
  assign z_out  = r_z;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_cin    <= 1'b0;
      r_result <= 8'h00;
      r_c      <= 1'b0;
      r_vf     <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
`ifdef ADC_SBC_DECIMAL_EN
      r_s      <= 8'h00;
      r_sub    <= 1'b0;
      r_dec    <= 1'b0;
      r_co     <= 1'b0;
      r_hc     <= 1'b0;
      r_v      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_cin   <= carry_in;
            r_state <= ADD;
`ifdef ADC_SBC_DECIMAL_EN
            r_sub   <= sub;
            r_dec   <= decimal;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        ADD: begin
`ifdef ADC_SBC_DECIMAL_EN
          r_s  <= w_sum;
          r_co <= w_co;
          r_hc <= r_a[4] ^ r_b[4] ^ w_sum[4];
          r_v  <= w_v;
          if (r_dec) begin
            r_state <= ADJ;
          end else begin
            r_result <= w_sum;
            r_c      <= w_co;
            r_vf     <= w_v;
            r_n      <= w_sum[7];
            r_z      <= (w_sum == 8'h00);
            r_state  <= DONE;
          end
`else
          r_result <= w_sum;
          r_c      <= w_co;
          r_vf     <= w_v;
          r_n      <= w_sum[7];
          r_z      <= (w_sum == 8'h00);
          r_state  <= DONE;
`endif
        end
`ifdef ADC_SBC_DECIMAL_EN
        ADJ: begin
          r_result <= w_sum;
          r_c      <= r_sub ? r_co : w_hi;
          r_vf     <= r_v;
          r_n      <= w_sum[7];
          r_z      <= (w_sum == 8'h00);
          r_state  <= DONE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_sbc_seq.sv
// tb_adc_sbc_seq: directed checks of adc_sbc_seq results, flags, latency and handshake.
module tb_adc_sbc_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, sub = 1'b0, decimal = 1'b0, carry_in = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic [7:0] result;
  logic       c_out, v_out, n_out, z_out, busy, done;
  int         checks = 0, failures = 0;

  adc_sbc_seq dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .decimal(decimal),
    .a(a), .b(b), .carry_in(carry_in), .result(result),
    .c_out(c_out), .v_out(v_out), .n_out(n_out), .z_out(z_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Issues one start and counts edges (sample edge = 1) until done is seen, bounded.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input logic isub, input logic idec, output int lat);
    @(negedge clk);
    a = ia; b = ib; carry_in = icin; sub = isub; decimal = idec; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if ({c_out, v_out, n_out, z_out} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {c_out, v_out, n_out, z_out}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_binary;
    logic [7:0] va [5] = '{8'h00, 8'h94, 8'h50, 8'h00, 8'h05};
    logic [7:0] vb [5] = '{8'h77, 8'hF7, 8'h50, 8'h01, 8'h05};
    logic       vc [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] er [5] = '{8'h78, 8'h8B, 8'hA0, 8'hFF, 8'h00};
    logic [3:0] ef [5] = '{4'b0000, 4'b1010, 4'b0110, 4'b0010, 4'b1001};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vc[i], vs[i], 1'b0, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL bin%0d_latency got=%0d exp=2", i, lat); end
      checks++; if (result !== er[i]) begin failures++; $display("FAIL bin%0d_result got=%h exp=%h", i, result, er[i]); end
      checks++; if ({c_out, v_out, n_out, z_out} !== ef[i]) begin failures++; $display("FAIL bin%0d_flags CVNZ got=%b exp=%b", i, {c_out, v_out, n_out, z_out}, ef[i]); end
    end
  endtask

  task automatic test_decimal;
`ifdef ADC_SBC_DECIMAL_EN
    logic [7:0] va [3] = '{8'h58, 8'h40, 8'h46};
    logic [7:0] vb [3] = '{8'h46, 8'h13, 8'h12};
    logic       vs [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] er [3] = '{8'h05, 8'h27, 8'h34};
    logic [3:0] ef [3] = '{4'b1100, 4'b1000, 4'b1000};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b1, vs[i], 1'b1, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL dec%0d_latency got=%0d exp=3", i, lat); end
      checks++; if (result !== er[i]) begin failures++; $display("FAIL dec%0d_result got=%h exp=%h", i, result, er[i]); end
      checks++; if ({c_out, v_out, n_out, z_out} !== ef[i]) begin failures++; $display("FAIL dec%0d_flags CVNZ got=%b exp=%b", i, {c_out, v_out, n_out, z_out}, ef[i]); end
    end
`else
    int lat;
    do_op(8'h58, 8'h46, 1'b1, 1'b0, 1'b1, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL nodec_latency got=%0d exp=2", lat); end
    checks++; if (result !== 8'h9F) begin failures++; $display("FAIL nodec_result got=%h exp=9f", result); end
    checks++; if ({c_out, v_out, n_out, z_out} !== 4'b0110) begin failures++; $display("FAIL nodec_flags CVNZ got=%b exp=0110", {c_out, v_out, n_out, z_out}); end
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (result !== 8'h46) begin failures++; $display("FAIL b2b_first_result got=%h exp=46", result); end
    do_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
    checks++; if (result !== 8'h30) begin failures++; $display("FAIL b2b_result got=%h exp=30", result); end
    checks++; if ({c_out, v_out, n_out, z_out} !== 4'b0000) begin failures++; $display("FAIL b2b_flags CVNZ got=%b exp=0000", {c_out, v_out, n_out, z_out}); end
  endtask

  task automatic test_ignore_start;
    int cnt = 0;
    @(negedge clk);
    a = 8'h01; b = 8'h02; carry_in = 1'b0; sub = 1'b0; decimal = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (done) cnt++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    checks++; if (cnt !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", cnt); end
    checks++; if (result !== 8'h03) begin failures++; $display("FAIL ign_result got=%h exp=03", result); end
  endtask

  task automatic test_reset_mid;
    int cnt = 0;
    @(negedge clk);
    a = 8'h58; b = 8'h46; carry_in = 1'b1; sub = 1'b0; decimal = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef ADC_SBC_DECIMAL_EN
    @(posedge clk); #1;
`endif
    rst = 1'b1;
    #1;
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL rstmid_result got=%h exp=00", result); end
    checks++; if ({c_out, v_out, n_out, z_out} !== 4'b0000) begin failures++; $display("FAIL rstmid_flags got=%b exp=0000", {c_out, v_out, n_out, z_out}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    checks++; if (cnt !== 0) begin failures++; $display("FAIL rstmid_done_count got=%0d exp=0", cnt); end
  endtask

  initial begin
    test_reset;
    test_binary;
    test_decimal;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
